// File: rtl/ntt_stage_ctrl_pkg.sv
// Shared types and helpers for the NTT stage-sequencing controller.
// Holds the FSM state encoding and the functions that derive the stage
// schedule (first span exponent, number of stages) from LOG_N and radix mode.
package ntt_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_GAP   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } ntt_state_e;

    // True when radix-4 mode needs one leading radix-2 stage (odd LOG_N).
    function automatic bit is_mixed(input int log_n);
        return (log_n % 2) == 1;
    endfunction

    // Span exponent of the very first stage of a transform.
    // Radix-2 and mixed radix-4 both open with the radix-2 stage p = LOG_N-1.
    function automatic int first_stage(input int log_n, input bit r4);
        if (!r4 || is_mixed(log_n)) begin
            return log_n - 1;
        end
        return log_n / 2 - 1;
    endfunction

    // Span exponent of the first radix-4 stage (after the optional radix-2 stage).
    function automatic int r4_top_stage(input int log_n);
        return (log_n - (is_mixed(log_n) ? 1 : 0)) / 2 - 1;
    endfunction

    // Total number of stages the controller walks for a transform.
    function automatic int stage_count(input int log_n, input bit r4);
        if (!r4) begin
            return log_n;
        end
        return log_n / 2 + (is_mixed(log_n) ? 1 : 0);
    endfunction

endpackage

// File: rtl/ntt_stage_ctrl_if.sv
// Control/status bundle between the top-level sequencer and the stage controller.
//
// Handshake semantics: start is a request sampled only while the controller is
// idle; busy acknowledges it from the following cycle until the done pulse
// (inclusive). rd_en and wr_en are single-cycle qualifiers with no ready:
// stage/k/j/r4_active/last are meaningful only in a cycle where rd_en=1. The
// only backpressure is hold, which stalls issue but never the write-back path.
// fsm_state exposes the controller state for observation only.
interface ntt_stage_ctrl_if #(
    parameter int LOG_N = 6,
    parameter int SW    = 4
);
    import ntt_ctrl_pkg::*;

    logic             start;
    logic             radix4;
    logic             hold;
    logic             busy;
    logic             rd_en;
    logic             wr_en;
    logic             r4_active;
    logic [SW-1:0]    stage;
    logic [LOG_N-1:0] k;
    logic [LOG_N-1:0] j;
    logic             last;
    logic             done;
    ntt_state_e       fsm_state;

    // Sequencer side: issues requests, observes progress.
    modport master (
        output start, radix4, hold,
        input  busy, rd_en, wr_en, r4_active, stage, k, j, last, done, fsm_state
    );

    // Controller side.
    modport slave (
        input  start, radix4, hold,
        output busy, rd_en, wr_en, r4_active, stage, k, j, last, done, fsm_state
    );

endinterface

// File: rtl/ntt_stage_ctrl_delay_line.sv
// Generic fixed-latency shift register. Each bit of din reappears on dout
// exactly DEPTH cycles later; asynchronous reset clears every slot so that
// in-flight entries are discarded.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    // Shift every cycle; slot 0 takes the new input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// NTT stage-sequencing controller. After an accepted start it walks every
// butterfly of an N = 2^LOG_N point transform, one per non-held cycle, in
// radix-2 or radix-4 order (odd LOG_N in radix-4 mode opens with a single
// radix-2 stage). j is the inner (within-group) index, k the group index and
// stage the span exponent p, counting down to 0. wr_en follows rd_en by
// PIPE_LAT cycles; done pulses the cycle after the final write.
module ntt_stage_ctrl #(
    parameter int LOG_N     = 6,
    parameter int PIPE_LAT  = 14,
    parameter int STAGE_GAP = 0,
    parameter int SW        = 4
) (
    input  logic           clk,
    input  logic           rst,
    ntt_stage_ctrl_if.slave bus
);
    import ntt_ctrl_pkg::*;

    // Bounds are compared in LOG_N+1 bits so the N/2 group count never wraps.
    localparam int CW = LOG_N + 1;
    // Exponent width: a radix-4 span exponent is 2p, one bit wider than p.
    localparam int EW = SW + 2;
    localparam logic [SW-1:0] P_R2  = SW'(first_stage(LOG_N, 1'b0));
    localparam logic [SW-1:0] P_R4  = SW'(r4_top_stage(LOG_N));
    localparam bit            MIXED = is_mixed(LOG_N);
    localparam int            GW    = (STAGE_GAP > 0) ? $clog2(STAGE_GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = (STAGE_GAP > 0) ? GW'(STAGE_GAP - 1) : '0;

    ntt_state_e       state_q, state_d;
    logic [LOG_N-1:0] j_q, j_d;
    logic [LOG_N-1:0] k_q, k_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic             cur_r4_q, cur_r4_d;   // current stage is radix-4
    logic             mode_r4_q, mode_r4_d; // radix4 input latched at start
    logic [GW-1:0]    gap_q, gap_d;

    logic [EW-1:0]    j_exp, k_exp;
    logic [CW-1:0]    j_max, k_max;
    logic             j_end, k_end, final_stage;
    logic             rd_en_c, last_c;
    logic [1:0]       dl_in, dl_out;

    // Per-stage loop bounds: span 2^p (or 4^p) butterflies per group and
    // (N/2)/2^p (or (N/4)/4^p) groups per stage.
    always_comb begin
        j_exp = cur_r4_q ? {1'b0, stage_q, 1'b0} : {2'b00, stage_q};
        k_exp = cur_r4_q ? (EW'(LOG_N - 2) - j_exp) : (EW'(LOG_N - 1) - j_exp);
        j_max = (CW'(1) << j_exp) - CW'(1);
        k_max = (CW'(1) << k_exp) - CW'(1);
        j_end = ({1'b0, j_q} == j_max);
        k_end = ({1'b0, k_q} == k_max);
        final_stage = (stage_q == '0);
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            j_q       <= '0;
            k_q       <= '0;
            stage_q   <= '0;
            cur_r4_q  <= 1'b0;
            mode_r4_q <= 1'b0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            k_q       <= k_d;
            stage_q   <= stage_d;
            cur_r4_q  <= cur_r4_d;
            mode_r4_q <= mode_r4_d;
            gap_q     <= gap_d;
        end
    end

    // Next-state, counter advance and issue strobes.
    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        k_d       = k_q;
        stage_d   = stage_q;
        cur_r4_d  = cur_r4_q;
        mode_r4_d = mode_r4_q;
        gap_d     = gap_q;
        rd_en_c   = 1'b0;
        last_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_RUN;
                    j_d       = '0;
                    k_d       = '0;
                    mode_r4_d = bus.radix4;
                    if (bus.radix4 && !MIXED) begin
                        stage_d  = P_R4;
                        cur_r4_d = 1'b1;
                    end else begin
                        stage_d  = P_R2;
                        cur_r4_d = 1'b0;
                    end
                end
            end

            ST_RUN: begin
                if (!bus.hold) begin
                    rd_en_c = 1'b1;
                    last_c  = j_end && k_end && final_stage;
                    if (last_c) begin
                        // Counters keep the final butterfly's values while draining.
                        state_d = ST_DRAIN;
                    end else if (!j_end) begin
                        j_d = j_q + LOG_N'(1);
                    end else begin
                        j_d = '0;
                        if (!k_end) begin
                            k_d = k_q + LOG_N'(1);
                        end else begin
                            k_d = '0;
                            // Leaving the leading radix-2 stage of a mixed transform.
                            if (mode_r4_q && !cur_r4_q) begin
                                stage_d  = P_R4;
                                cur_r4_d = 1'b1;
                            end else begin
                                stage_d = stage_q - SW'(1);
                            end
                            if (STAGE_GAP > 0) begin
                                state_d = ST_GAP;
                                gap_d   = '0;
                            end
                        end
                    end
                end
            end

            ST_GAP: begin
                // Bubble cycles run regardless of hold.
                if (gap_q == GAP_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end

            ST_DRAIN: begin
                // The delayed last flag marks the cycle of the final write.
                if (dl_out[1]) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Carry issue and last-issue markers through the butterfly latency.
    assign dl_in = {last_c, rd_en_c};

    delay_line #(
        .WIDTH (2),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (dl_in),
        .dout (dl_out)
    );

    assign bus.rd_en     = rd_en_c;
    assign bus.wr_en     = dl_out[0];
    assign bus.last      = last_c;
    assign bus.r4_active = rd_en_c & cur_r4_q;
    assign bus.stage     = stage_q;
    assign bus.k         = k_q;
    assign bus.j         = j_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Bench for ntt_stage_ctrl. Three instances cover LOG_N=6, LOG_N=7 and
// LOG_N=6 with STAGE_GAP=3; only one is exercised at a time and sel routes
// its outputs to a shared scoreboard.
module tb_ntt_stage_ctrl;
    import ntt_ctrl_pkg::*;

    localparam int PIPE_LAT = 14;
    localparam int W        = 46; // {cycle[15:0], r4, last, stage[3:0], k[11:0], j[11:0]}

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus signals ----------------
    logic start  = 1'b0;
    logic radix4 = 1'b0;
    logic hold   = 1'b0;
    int   sel    = 0;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    int           wr_q[$];
    int           done_q[$];
    int           iss_cnt  = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;

    // ---------------- DUTs ----------------
    ntt_stage_ctrl_if #(.LOG_N(6), .SW(4)) if_a ();
    ntt_stage_ctrl_if #(.LOG_N(7), .SW(4)) if_b ();
    ntt_stage_ctrl_if #(.LOG_N(6), .SW(4)) if_c ();

    assign if_a.start  = (sel == 0) ? start  : 1'b0;
    assign if_a.radix4 = (sel == 0) ? radix4 : 1'b0;
    assign if_a.hold   = (sel == 0) ? hold   : 1'b0;
    assign if_b.start  = (sel == 1) ? start  : 1'b0;
    assign if_b.radix4 = (sel == 1) ? radix4 : 1'b0;
    assign if_b.hold   = (sel == 1) ? hold   : 1'b0;
    assign if_c.start  = (sel == 2) ? start  : 1'b0;
    assign if_c.radix4 = (sel == 2) ? radix4 : 1'b0;
    assign if_c.hold   = (sel == 2) ? hold   : 1'b0;

    ntt_stage_ctrl #(.LOG_N(6), .PIPE_LAT(PIPE_LAT), .STAGE_GAP(0), .SW(4))
        u_a (.clk(clk), .rst(rst_n), .bus(if_a));
    ntt_stage_ctrl #(.LOG_N(7), .PIPE_LAT(PIPE_LAT), .STAGE_GAP(0), .SW(4))
        u_b (.clk(clk), .rst(rst_n), .bus(if_b));
    ntt_stage_ctrl #(.LOG_N(6), .PIPE_LAT(PIPE_LAT), .STAGE_GAP(3), .SW(4))
        u_c (.clk(clk), .rst(rst_n), .bus(if_c));

    // ---------------- output mux ----------------
    logic        m_busy, m_rd, m_wr, m_r4, m_last, m_done;
    logic [3:0]  m_stage;
    logic [11:0] m_k, m_j;
    ntt_state_e  m_state;

    always_comb begin
        m_busy = if_a.busy;  m_rd = if_a.rd_en;  m_wr = if_a.wr_en;
        m_r4 = if_a.r4_active; m_last = if_a.last; m_done = if_a.done;
        m_stage = if_a.stage; m_k = 12'(if_a.k); m_j = 12'(if_a.j);
        m_state = if_a.fsm_state;
        if (sel == 1) begin
            m_busy = if_b.busy;  m_rd = if_b.rd_en;  m_wr = if_b.wr_en;
            m_r4 = if_b.r4_active; m_last = if_b.last; m_done = if_b.done;
            m_stage = if_b.stage; m_k = 12'(if_b.k); m_j = 12'(if_b.j);
            m_state = if_b.fsm_state;
        end else if (sel == 2) begin
            m_busy = if_c.busy;  m_rd = if_c.rd_en;  m_wr = if_c.wr_en;
            m_r4 = if_c.r4_active; m_last = if_c.last; m_done = if_c.done;
            m_stage = if_c.stage; m_k = 12'(if_c.k); m_j = 12'(if_c.j);
            m_state = if_c.fsm_state;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int t, input bit r4, input bit lst,
                                        input int p, input int kk, input int jj);
        return {16'(t), r4, lst, 4'(p), 12'(kk), 12'(jj)};
    endfunction

    // Reference schedule: nested loops over stages, groups and butterflies,
    // with the cycle each issue is due (holes for hold and stage gaps).
    task automatic gen_run(input int log_n, input bit r4, input int gap, input int t0,
                           input int h0, input int hlen);
        int ps[$];
        bit rs[$];
        int t, span, grp, n;
        bit lst;
        n = 1 << log_n;
        if (!r4) begin
            for (int p = log_n - 1; p >= 0; p--) begin ps.push_back(p); rs.push_back(1'b0); end
        end else begin
            if (log_n % 2 == 1) begin ps.push_back(log_n - 1); rs.push_back(1'b0); end
            for (int p = log_n / 2 - 1; p >= 0; p--) begin ps.push_back(p); rs.push_back(1'b1); end
        end
        t = t0;
        for (int s = 0; s < ps.size(); s++) begin
            span = rs[s] ? (1 << (2 * ps[s])) : (1 << ps[s]);
            grp  = rs[s] ? (n / 4) / span : (n / 2) / span;
            for (int kk = 0; kk < grp; kk++) begin
                for (int jj = 0; jj < span; jj++) begin
                    while (hlen > 0 && t >= h0 && t < h0 + hlen) t++;
                    lst = (s == ps.size() - 1) && (kk == grp - 1) && (jj == span - 1);
                    exp_q.push_back(mk(t, rs[s], lst, ps[s], kk, jj));
                    wr_q.push_back(t + PIPE_LAT);
                    if (lst) done_q.push_back(t + PIPE_LAT + 1);
                    t++;
                end
            end
            if (s < ps.size() - 1) t += gap;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [W-1:0] got;
        logic [W-1:0] exp;
        int e;
        if (rst_n) begin
            if (m_rd) begin
                iss_cnt++;
                got = {16'(cyc), m_r4, m_last, m_stage, m_k, m_j};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL issue_unexpected got cyc=%0d stage=%0d k=%0d j=%0d",
                             cyc, m_stage, m_k, m_j);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL issue got cyc=%0d r4=%b last=%b stage=%0d k=%0d j=%0d exp cyc=%0d r4=%b last=%b stage=%0d k=%0d j=%0d",
                                 got[45:30], got[29], got[28], got[27:24], got[23:12], got[11:0],
                                 exp[45:30], exp[29], exp[28], exp[27:24], exp[23:12], exp[11:0]);
                    end
                end
            end
            if (m_wr) begin
                checks++;
                if (wr_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected got cyc=%0d exp none", cyc);
                end else begin
                    e = wr_q.pop_front();
                    if (cyc != e) begin
                        failures++;
                        $display("FAIL wr_cycle got=%0d exp=%0d", cyc, e);
                    end
                end
            end
            if (m_done) begin
                done_cnt++;
                done_cyc = cyc;
                checks++;
                if (done_q.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected got cyc=%0d exp none", cyc);
                end else begin
                    e = done_q.pop_front();
                    if (cyc != e) begin
                        failures++;
                        $display("FAIL done_cycle got=%0d exp=%0d", cyc, e);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_test(input string tag, input int d, input bit r4, input int h_off,
                            input int hlen, input bit poke, input int exp_iss,
                            input int exp_done_gap);
        int s, h0, iss0, dc0, log_n, gap;
        bit got_done;
        sel   = d;
        log_n = (d == 1) ? 7 : 6;
        gap   = (d == 2) ? 3 : 0;
        @(posedge clk); #1;
        s  = cyc;
        h0 = s + 1 + h_off;
        gen_run(log_n, r4, gap, s + 1, h0, hlen);
        iss0 = iss_cnt;
        dc0  = done_cnt;
        radix4 = r4;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        radix4 = ~r4; // must be ignored while busy
        chk({tag, "_busy_run"}, int'(m_busy), 1);
        got_done = 1'b0;
        for (int i = 0; i < 1000 && !got_done; i++) begin
            hold  = (hlen > 0 && cyc >= h0 && cyc < h0 + hlen);
            start = (poke && cyc == s + 40);
            @(posedge clk); #1;
            got_done = (done_cnt != dc0);
        end
        start  = 1'b0;
        hold   = 1'b0;
        radix4 = 1'b0;
        chk({tag, "_done_seen"}, int'(got_done), 1);
        chk({tag, "_issue_count"}, iss_cnt - iss0, exp_iss);
        chk({tag, "_done_latency"}, done_cyc - (s + 1), exp_done_gap);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_busy_after"}, int'(m_busy), 0);
        chk({tag, "_queues_empty"}, exp_q.size() + wr_q.size() + done_q.size(), 0);
        exp_q.delete();
        wr_q.delete();
        done_q.delete();
    endtask

    task automatic reset_test();
        int s, dc0;
        sel = 0;
        @(posedge clk); #1;
        s = cyc;
        gen_run(6, 1'b0, 0, s + 1, 0, 0);
        radix4 = 1'b0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Issue 140 belongs to stage p=1 (issues 128..159).
        while (cyc < s + 1 + 140) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_stage", int'(m_stage), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_flags_zero", int'({m_busy, m_rd, m_wr, m_r4, m_last, m_done}), 0);
        chk("rst_counters_zero", int'({m_stage, m_k, m_j}), 0);
        chk("rst_state_idle", int'(m_state), int'(ST_IDLE));
        exp_q.delete();
        wr_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dc0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt - dc0, 0);
        chk("rst_busy_low", int'(m_busy), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags_zero", int'({m_busy, m_rd, m_wr, m_r4, m_last, m_done}), 0);
        chk("reset_counters_zero", int'({m_stage, m_k, m_j}), 0);
        chk("reset_state_idle", int'(m_state), int'(ST_IDLE));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // done latency = (issues-1) + gap cycles + hold cycles + PIPE_LAT + 1
        run_test("r2_l6",      0, 1'b0, 0,  0, 1'b0, 192, 206);
        run_test("r4_l6",      0, 1'b1, 0,  0, 1'b0,  48,  62);
        run_test("r4_l7",      1, 1'b1, 0,  0, 1'b0, 160, 174);
        run_test("r4_l6_gap3", 2, 1'b1, 0,  0, 1'b0,  48,  68);
        run_test("hold5",      0, 1'b0, 50, 5, 1'b1, 192, 211);
        reset_test();
        run_test("post_rst",   0, 1'b0, 0,  0, 1'b0, 192, 206);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
